// File: rtl/unidade_controle_rodadas_pkg.sv
// State codes for the memory-game round sequencer, shared by the FSM and its debug decoder.
// The codes double as the 7-segment debug value, so they are fixed 4-bit constants.
package unidade_controle_rodadas_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
  localparam logic [3:0] ST_ESPERA         = 4'h3;
  localparam logic [3:0] ST_REGISTRA       = 4'h4;
  localparam logic [3:0] ST_COMPARA        = 4'h5;
  localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h6;
  localparam logic [3:0] ST_PROXIMA_RODADA = 4'h8;
  localparam logic [3:0] ST_FINAL_ACERTO   = 4'hA;
  localparam logic [3:0] ST_FINAL_TIMEOUT  = 4'hD;
  localparam logic [3:0] ST_FINAL_ERRO     = 4'hE;
  localparam logic [3:0] ST_INVALIDO       = 4'hF;

  function automatic logic estado_valido(input logic [3:0] estado);
    case (estado)
      ST_INICIAL, ST_PREPARACAO, ST_INICIA_RODADA, ST_ESPERA,
      ST_REGISTRA, ST_COMPARA, ST_PROXIMA_JOGADA, ST_PROXIMA_RODADA,
      ST_FINAL_ACERTO, ST_FINAL_TIMEOUT, ST_FINAL_ERRO: estado_valido = 1'b1;
      default:                                          estado_valido = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play response timer: clears on zera, counts on conta, saturates at all-ones.
// tmo flags the last allowed cycle so the FSM leaves espera exactly TIMEOUT_CICLOS clocks after entry.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int W_TIMER        = 13
) (
  input  logic clock,
  input  logic reset_n,
  input  logic zera,
  input  logic conta,
  output logic tmo
);

  localparam logic [W_TIMER-1:0] LIMITE = W_TIMER'(TIMEOUT_CICLOS - 1);
  localparam logic [W_TIMER-1:0] MAXIMO = '1;

  logic [W_TIMER-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (zera)
      timer_d = '0;
    else if (conta && (timer_q != MAXIMO))
      timer_d = timer_q + W_TIMER'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end

  assign tmo = conta && (timer_q == LIMITE);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore FSM sequencing the memory game over progressive rounds with a per-play timeout.
// Outputs depend on the current state only; a play pulse reaches compara two clocks later.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int W_TIMER        = 13
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  logic [3:0] estado_q, estado_d;
  logic       em_espera;
  logic       tmo;

  assign em_espera = (estado_q == ST_ESPERA);

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
    .W_TIMER       (W_TIMER)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (!em_espera),
    .conta  (em_espera),
    .tmo    (tmo)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      estado_q <= ST_INICIAL;
    else
      estado_q <= estado_d;
  end

  always_comb begin
    estado_d = ST_INICIAL;
    case (estado_q)
      ST_INICIAL:        estado_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:     estado_d = ST_INICIA_RODADA;
      ST_INICIA_RODADA:  estado_d = ST_ESPERA;
      // A play arriving on the timeout cycle still counts.
      ST_ESPERA:         estado_d = jogada ? ST_REGISTRA :
                                    (tmo ? ST_FINAL_TIMEOUT : ST_ESPERA);
      ST_REGISTRA:       estado_d = ST_COMPARA;
      ST_COMPARA: begin
        if (!igual)      estado_d = ST_FINAL_ERRO;
        else if (!fimE)  estado_d = ST_PROXIMA_JOGADA;
        else if (!fimL)  estado_d = ST_PROXIMA_RODADA;
        else             estado_d = ST_FINAL_ACERTO;
      end
      ST_PROXIMA_JOGADA: estado_d = ST_ESPERA;
      ST_PROXIMA_RODADA: estado_d = ST_INICIA_RODADA;
      ST_FINAL_ACERTO,
      ST_FINAL_ERRO,
      ST_FINAL_TIMEOUT:  estado_d = iniciar ? ST_PREPARACAO : estado_q;
      default:           estado_d = ST_INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (estado_q)
      ST_INICIAL, ST_PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      ST_INICIA_RODADA:  zeraE     = 1'b1;
      ST_REGISTRA:       registraR = 1'b1;
      ST_PROXIMA_JOGADA: contaE    = 1'b1;
      ST_PROXIMA_RODADA: contaL    = 1'b1;
      ST_FINAL_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      ST_FINAL_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      ST_FINAL_TIMEOUT: begin
        errou   = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_valido(estado_q) ? estado_q : ST_INVALIDO;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for the round sequencer with an 8-cycle play timeout.
module tb_unidade_controle_rodadas;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar, jogada, igual, fimE, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int vectors    = 0;
  int miscompares = 0;
  int n_contaE   = 0;
  int n_contaL   = 0;

  unidade_controle_rodadas #(
    .TIMEOUT_CICLOS(8),
    .W_TIMER       (4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .iniciar  (iniciar),
    .jogada   (jogada),
    .igual    (igual),
    .fimE     (fimE),
    .fimL     (fimL),
    .zeraE    (zeraE),
    .contaE   (contaE),
    .zeraL    (zeraL),
    .contaL   (contaL),
    .zeraR    (zeraR),
    .registraR(registraR),
    .acertou  (acertou),
    .errou    (errou),
    .timeout  (timeout),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (contaE) n_contaE++;
    if (contaL) n_contaL++;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM in espera; returns at the negedge showing the compara outcome.
  task automatic jogar(input logic ig, input logic fe, input logic fl, input int esperado);
    jogada = 1'b1;
    tick();
    check("registra_estado", int'(db_estado), 4);
    check("registraR", int'(registraR), 1);
    jogada = 1'b0;
    igual = ig;
    fimE  = fe;
    fimL  = fl;
    tick();
    check("compara_estado", int'(db_estado), 5);
    tick();
    check("pos_compara_estado", int'(db_estado), esperado);
    igual = 1'b0;
    fimE  = 1'b0;
    fimL  = 1'b0;
  endtask

  // From a final state: iniciar -> preparacao -> inicia_rodada -> espera.
  task automatic reiniciar();
    iniciar = 1'b1;
    tick();
    check("rein_preparacao", int'(db_estado), 1);
    check("rein_zera", int'({zeraE, zeraL, zeraR}), 3'b111);
    check("rein_pronto", int'(pronto), 0);
    iniciar = 1'b0;
    tick();
    check("rein_inicia_rodada", int'(db_estado), 2);
    check("rein_zera_so_E", int'({zeraE, zeraL, zeraR}), 3'b100);
    tick();
    check("rein_espera", int'(db_estado), 3);
  endtask

  initial begin
    reset_n = 1'b0;
    iniciar = 1'b0;
    jogada  = 1'b0;
    igual   = 1'b0;
    fimE    = 1'b0;
    fimL    = 1'b0;
    tick();
    tick();
    check("rst_estado", int'(db_estado), 0);
    check("rst_zera", int'({zeraE, zeraL, zeraR}), 3'b111);
    check("rst_saidas", int'({contaE, contaL, registraR, acertou, errou, timeout, pronto}), 0);
    reset_n = 1'b1;
    tick();
    check("inicial_hold", int'(db_estado), 0);

    // Game 1: full win over four rounds.
    iniciar = 1'b1;
    tick();
    check("preparacao", int'(db_estado), 1);
    iniciar = 1'b0;
    tick();
    check("inicia_rodada", int'(db_estado), 2);
    check("inicia_zeraE", int'(zeraE), 1);
    tick();
    check("espera", int'(db_estado), 3);
    n_contaE = 0;
    n_contaL = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p <= r; p++) begin
        if (p != r) begin
          jogar(1'b1, 1'b0, 1'b0, 6);
          check("contaE_pulso", int'(contaE), 1);
          tick();
          check("volta_espera", int'(db_estado), 3);
        end else if (r != 3) begin
          jogar(1'b1, 1'b1, 1'b0, 8);
          check("contaL_pulso", int'(contaL), 1);
          tick();
          check("nova_rodada", int'(db_estado), 2);
          tick();
          check("nova_espera", int'(db_estado), 3);
        end else begin
          jogar(1'b1, 1'b1, 1'b1, 10);
        end
      end
    end
    check("win_contaL_total", n_contaL, 3);
    check("win_contaE_total", n_contaE, 6);
    check("win_flags", int'({acertou, pronto, errou, timeout}), 4'b1100);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    check("win_ignora_jogada", int'(db_estado), 10);

    // Game 2: wrong second play of round 2.
    reiniciar();
    jogar(1'b1, 1'b1, 1'b0, 8);
    tick();
    tick();
    check("g2_espera", int'(db_estado), 3);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("g2_ignora_iniciar", int'(db_estado), 3);
    jogar(1'b1, 1'b0, 1'b0, 6);
    tick();
    n_contaE = 0;
    jogar(1'b0, 1'b1, 1'b0, 14);
    tick();
    check("erro_hold", int'(db_estado), 14);
    check("erro_flags", int'({acertou, errou, timeout, pronto}), 4'b0101);
    check("erro_sem_contaE", n_contaE, 0);

    // Game 3: no play -> timeout 8 clocks after entering espera.
    reiniciar();
    for (int i = 0; i < 7; i++) tick();
    check("tmo_ainda_espera", int'(db_estado), 3);
    tick();
    check("tmo_estado", int'(db_estado), 13);
    check("tmo_flags", int'({acertou, errou, timeout, pronto}), 4'b0111);
    tick();
    check("tmo_hold", int'(db_estado), 13);

    // Game 4: play arrives on the timeout cycle; timer restarted from 0.
    reiniciar();
    for (int i = 0; i < 7; i++) tick();
    check("simul_espera", int'(db_estado), 3);
    jogar(1'b1, 1'b0, 1'b0, 6);
    check("simul_sem_timeout", int'({timeout, errou}), 0);
    tick();
    check("simul_volta_espera", int'(db_estado), 3);

    // Asynchronous reset mid-espera.
    tick();
    reset_n = 1'b0;
    #2;
    check("arst_estado", int'(db_estado), 0);
    check("arst_zera", int'({zeraE, zeraL, zeraR}), 3'b111);
    check("arst_pronto", int'(pronto), 0);
    iniciar = 1'b1;
    tick();
    check("arst_hold", int'(db_estado), 0);
    iniciar = 1'b0;
    reset_n = 1'b1;
    tick();
    check("pos_arst", int'(db_estado), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
